// File: rtl/mul_div_unit_if.sv
// rtl/mul_div_unit_if.sv - request/result bundle for the multiply/divide engine

interface mul_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] zhigh;
    logic [WIDTH-1:0] zlow;

    modport master (
        output start, op, a, b,
        input  busy, done, div_by_zero, zhigh, zlow
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, div_by_zero, zhigh, zlow
    );
endinterface

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - multi-cycle signed Booth multiply / non-restoring divide engine
// One bit per clock; result lands on zhigh/zlow in FIX and done pulses in DONE.

module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic           clock,
    input  logic           clear,
    mul_div_unit_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] m_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH+1:0] hi_q;
    logic             q1_q;
    logic             op_q;
    logic             sa_q;
    logic             sb_q;
    logic             dz_q;
    logic             dz_flag_q;
    logic [WIDTH-1:0] zhigh_q;
    logic [WIDTH-1:0] zlow_q;

    logic             b_zero;
    logic             last_step;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;

    logic [WIDTH+1:0] m_ext;
    logic [WIDTH+1:0] booth_sum;
    logic [WIDTH+1:0] mul_hi_n;
    logic [WIDTH-1:0] mul_lo_n;
    logic             mul_q1_n;

    logic [WIDTH+1:0] d_ext;
    logic [WIDTH+1:0] div_shift;
    logic [WIDTH+1:0] div_hi_n;
    logic [WIDTH-1:0] div_lo_n;

    logic [WIDTH+1:0] rem_fix;
    logic [WIDTH-1:0] rem_mag;
    logic [WIDTH-1:0] quo_s;
    logic [WIDTH-1:0] rem_s;

    assign b_zero    = (bus.b == '0);
    assign last_step = (count_q == CW'(WIDTH - 1));
    // Unsigned magnitudes: |-2^(W-1)| still fits in WIDTH bits.
    assign a_abs     = bus.a[WIDTH-1] ? (~bus.a + 1'b1) : bus.a;
    assign b_abs     = bus.b[WIDTH-1] ? (~bus.b + 1'b1) : bus.b;

    // Booth step on {hi, lo, q1}; hi has two guard bits so a -2^(W-1) multiplicand cannot overflow.
    always_comb begin
        m_ext = {{2{a_q[WIDTH-1]}}, a_q};
        booth_sum = hi_q;
        case ({lo_q[0], q1_q})
            2'b01:   booth_sum = hi_q + m_ext;
            2'b10:   booth_sum = hi_q - m_ext;
            default: booth_sum = hi_q;
        endcase
        {mul_hi_n, mul_lo_n, mul_q1_n} = {booth_sum[WIDTH+1], booth_sum, lo_q};
    end

    // Non-restoring step: hi is the signed partial remainder, lo shifts dividend out and quotient in.
    always_comb begin
        d_ext     = {2'b00, m_q};
        div_shift = {hi_q[WIDTH:0], lo_q[WIDTH-1]};
        div_hi_n  = hi_q[WIDTH+1] ? (div_shift + d_ext) : (div_shift - d_ext);
        div_lo_n  = {lo_q[WIDTH-2:0], ~div_hi_n[WIDTH+1]};
    end

    always_comb begin
        rem_fix = hi_q[WIDTH+1] ? (hi_q + d_ext) : hi_q;
        rem_mag = rem_fix[WIDTH-1:0];
        quo_s   = (sa_q ^ sb_q) ? (~lo_q + 1'b1) : lo_q;
        rem_s   = sa_q ? (~rem_mag + 1'b1) : rem_mag;
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = (bus.op && b_zero) ? S_FIX : S_RUN;
                end
            end
            S_RUN: begin
                if (last_step) begin
                    state_d = S_FIX;
                end
            end
            S_FIX:   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            count_q   <= '0;
            a_q       <= '0;
            m_q       <= '0;
            lo_q      <= '0;
            hi_q      <= '0;
            q1_q      <= 1'b0;
            op_q      <= 1'b0;
            sa_q      <= 1'b0;
            sb_q      <= 1'b0;
            dz_q      <= 1'b0;
            dz_flag_q <= 1'b0;
            zhigh_q   <= '0;
            zlow_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        a_q       <= bus.a;
                        m_q       <= b_abs;
                        lo_q      <= bus.op ? a_abs : bus.b;
                        hi_q      <= '0;
                        q1_q      <= 1'b0;
                        op_q      <= bus.op;
                        sa_q      <= bus.a[WIDTH-1];
                        sb_q      <= bus.b[WIDTH-1];
                        dz_q      <= bus.op && b_zero;
                        dz_flag_q <= 1'b0;
                        count_q   <= '0;
                    end
                end
                S_RUN: begin
                    count_q <= count_q + 1'b1;
                    if (op_q) begin
                        hi_q <= div_hi_n;
                        lo_q <= div_lo_n;
                    end else begin
                        hi_q <= mul_hi_n;
                        lo_q <= mul_lo_n;
                        q1_q <= mul_q1_n;
                    end
                end
                S_FIX: begin
                    dz_flag_q <= dz_q;
                    if (dz_q) begin
                        zlow_q  <= '1;
                        zhigh_q <= a_q;
                    end else if (op_q) begin
                        zlow_q  <= quo_s;
                        zhigh_q <= rem_s;
                    end else begin
                        zlow_q  <= lo_q;
                        zhigh_q <= hi_q[WIDTH-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = (state_q == S_DONE);
    assign bus.div_by_zero = dz_flag_q;
    assign bus.zhigh       = zhigh_q;
    assign bus.zlow        = zlow_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - directed-vector bench for mul_div_unit

module tb_mul_div_unit;
    logic clock;
    logic clear;
    int   vectors;
    int   miscompares;

    mul_div_unit_if #(.WIDTH(32)) bus ();

    mul_div_unit #(.WIDTH(32)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Cycle n is the negedge after the n-th posedge counted from the capture edge (n=1).
    task automatic run_op(input logic op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                          output int lat, output int busy_n,
                          output logic [31:0] zlow_at1, output logic dz_at1);
        lat = 0;
        busy_n = 0;
        zlow_at1 = 'x;
        dz_at1 = 1'bx;
        @(negedge clock);
        bus.start = 1'b1;
        bus.op    = op_i;
        bus.a     = a_i;
        bus.b     = b_i;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clock);
            bus.start = 1'b0;
            bus.a     = ~a_i;
            bus.b     = b_i + 32'd1;
            if (n == 1) begin
                zlow_at1 = bus.zlow;
                dz_at1   = bus.div_by_zero;
            end
            if (bus.done) begin
                lat = n;
                break;
            end
            if (bus.busy) busy_n++;
        end
    endtask

    int          lat;
    int          busy_n;
    int          pulses;
    int          first_done;
    logic [31:0] zl1;
    logic        dz1;

    initial begin
        vectors     = 0;
        miscompares = 0;
        clear       = 1'b1;
        bus.start   = 1'b0;
        bus.op      = 1'b0;
        bus.a       = '0;
        bus.b       = '0;
        repeat (2) @(negedge clock);
        clear = 1'b0;
        @(negedge clock);
        check("reset_busy",  {63'd0, bus.busy},        64'd0);
        check("reset_done",  {63'd0, bus.done},        64'd0);
        check("reset_dz",    {63'd0, bus.div_by_zero}, 64'd0);
        check("reset_zhigh", {32'd0, bus.zhigh},       64'd0);
        check("reset_zlow",  {32'd0, bus.zlow},        64'd0);

        run_op(1'b0, 32'd7, 32'hFFFF_FFFD, lat, busy_n, zl1, dz1);
        check("mul7x-3_latency", 64'(lat),    64'd34);
        check("mul7x-3_busy",    64'(busy_n), 64'd33);
        check("mul7x-3_result",  {bus.zhigh, bus.zlow}, 64'hFFFF_FFFF_FFFF_FFEB);
        check("mul7x-3_busy_in_done", {63'd0, bus.busy}, 64'd1);
        @(negedge clock);
        check("mul7x-3_done_one_cycle", {63'd0, bus.done}, 64'd0);
        check("mul7x-3_idle_after",     {63'd0, bus.busy}, 64'd0);

        run_op(1'b0, 32'h8000_0000, 32'h8000_0000, lat, busy_n, zl1, dz1);
        check("mul_min_x_min", {bus.zhigh, bus.zlow}, 64'h4000_0000_0000_0000);
        run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, busy_n, zl1, dz1);
        check("mul_-1_x_-1", {bus.zhigh, bus.zlow}, 64'h0000_0000_0000_0001);

        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, lat, busy_n, zl1, dz1);
        check("div-7/2_latency", 64'(lat), 64'd34);
        check("div-7/2", {bus.zhigh, bus.zlow}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(1'b1, 32'd7, 32'hFFFF_FFFE, lat, busy_n, zl1, dz1);
        check("div7/-2", {bus.zhigh, bus.zlow}, 64'h0000_0001_FFFF_FFFD);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, busy_n, zl1, dz1);
        check("div_overflow", {bus.zhigh, bus.zlow}, 64'h0000_0000_8000_0000);
        check("div_overflow_no_flag", {63'd0, bus.div_by_zero}, 64'd0);

        run_op(1'b1, 32'd5, 32'd0, lat, busy_n, zl1, dz1);
        check("div0_latency", 64'(lat), 64'd2);
        check("div0_flag",    {63'd0, bus.div_by_zero}, 64'd1);
        check("div0_result",  {bus.zhigh, bus.zlow}, 64'h0000_0005_FFFF_FFFF);
        run_op(1'b0, 32'd2, 32'd3, lat, busy_n, zl1, dz1);
        check("hold_zlow_on_start", {32'd0, zl1}, 64'h0000_0000_FFFF_FFFF);
        check("dz_cleared_on_start", {63'd0, dz1}, 64'd0);
        check("mul2x3", {bus.zhigh, bus.zlow}, 64'd6);
        check("mul2x3_flag", {63'd0, bus.div_by_zero}, 64'd0);

        @(negedge clock);
        bus.start = 1'b1;
        bus.op    = 1'b0;
        bus.a     = 32'd3;
        bus.b     = 32'd4;
        for (int n = 1; n <= 9; n++) begin
            @(negedge clock);
            bus.start = 1'b0;
        end
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        check("clear_busy",  {63'd0, bus.busy},        64'd0);
        check("clear_done",  {63'd0, bus.done},        64'd0);
        check("clear_dz",    {63'd0, bus.div_by_zero}, 64'd0);
        check("clear_result", {bus.zhigh, bus.zlow},   64'd0);
        pulses = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clock);
            if (bus.done) pulses++;
        end
        check("clear_no_done", 64'(pulses), 64'd0);
        run_op(1'b1, 32'd100, 32'd7, lat, busy_n, zl1, dz1);
        check("div100/7", {bus.zhigh, bus.zlow}, 64'h0000_0002_0000_000E);

        @(negedge clock);
        bus.start = 1'b1;
        bus.op    = 1'b0;
        bus.a     = 32'd3;
        bus.b     = 32'd5;
        pulses     = 0;
        first_done = 0;
        for (int n = 1; n <= 45; n++) begin
            @(negedge clock);
            bus.start = 1'b0;
            if (n == 4) begin
                bus.start = 1'b1;
                bus.op    = 1'b1;
                bus.a     = 32'd100;
                bus.b     = 32'd9;
            end
            if (bus.done) begin
                pulses++;
                if (first_done == 0) first_done = n;
            end
        end
        check("busy_start_done_cycle", 64'(first_done), 64'd34);
        check("busy_start_one_pulse",  64'(pulses),     64'd1);
        check("busy_start_result", {bus.zhigh, bus.zlow}, 64'd15);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
